// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the LC-3b fetch stage
package fetch_pkg;

   localparam int FETCH_W        = 16;
   localparam int PC_INC_DEFAULT = 2;

   typedef enum logic {
      FETCH   = 1'b0,
      DISCARD = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [FETCH_W-1:0] pc;
      logic [FETCH_W-1:0] pc_plus2;
      logic [FETCH_W-1:0] instr;
   } fetch_out_t;

endpackage

// File: rtl/fetch_out_buf.sv
// rtl/fetch_out_buf.sv - one-entry valid/data holding buffer feeding the IF/ID register
module fetch_out_buf
   import fetch_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic       drain,
   input  logic       flush,
   input  fetch_out_t data_in,
   output logic       valid,
   output fetch_out_t data
);

   // flush beats load: a redirect squashes whatever arrives with it
   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= data_in;
      end else if (drain) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - LC-3b instruction fetch: PC, imem handshake, redirect; FETCH_PERF_EN adds perf counters
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int               WIDTH    = FETCH_W,
   parameter logic [WIDTH-1:0] RESET_PC = 16'h0000,
   parameter int               PC_INC   = PC_INC_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   output logic             imem_read,
   output logic [WIDTH-1:0] imem_address,
   input  logic [WIDTH-1:0] imem_rdata,
   input  logic             imem_resp,
   input  logic             branch_taken,
   input  logic [WIDTH-1:0] branch_target,
   input  logic             id_ready,
   output logic             if_valid,
   output logic [WIDTH-1:0] if_pc,
   output logic [WIDTH-1:0] if_pc_plus2,
   output logic [WIDTH-1:0] if_instr
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]      perf_wait_cycles,
   output logic [15:0]      perf_discards
`endif
);

   localparam logic [WIDTH-1:0] INC = WIDTH'(PC_INC);

   fetch_state_e     state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] pending_q, pending_d;
   logic [WIDTH-1:0] pc_seq;
   logic             buf_load;
   logic             buf_valid;
   logic             drop;
   fetch_out_t       buf_in;
   fetch_out_t       buf_out;

   assign pc_seq       = pc_q + INC;
   assign imem_address = pc_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= FETCH;
         pc_q      <= RESET_PC;
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pending_q <= pending_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      pending_d = pending_q;
      imem_read = 1'b0;
      buf_load  = 1'b0;
      drop      = 1'b0;
      case (state_q)
         FETCH: begin
            imem_read = !buf_valid || id_ready;
            if (branch_taken) begin
               // an unanswered request keeps pc_q so the address stays stable
               if (imem_read && !imem_resp) begin
                  pending_d = branch_target;
                  state_d   = DISCARD;
               end else begin
                  pc_d = branch_target;
                  drop = imem_read && imem_resp;
               end
            end else if (imem_read && imem_resp) begin
               buf_load = 1'b1;
               pc_d     = pc_seq;
            end
         end
         DISCARD: begin
            imem_read = 1'b1;
            if (imem_resp) begin
               drop    = 1'b1;
               state_d = FETCH;
               pc_d    = branch_taken ? branch_target : pending_q;
            end else if (branch_taken) begin
               pending_d = branch_target;
            end
         end
         default: state_d = FETCH;
      endcase
      if (reset) begin
         imem_read = 1'b0;
      end
   end

   assign buf_in.pc       = pc_q;
   assign buf_in.pc_plus2 = pc_seq;
   assign buf_in.instr    = imem_rdata;

   fetch_out_buf u_out_buf (
      .clk     (clk),
      .reset   (reset),
      .load    (buf_load),
      .drain   (buf_valid && id_ready),
      .flush   (branch_taken),
      .data_in (buf_in),
      .valid   (buf_valid),
      .data    (buf_out)
   );

   assign if_valid    = buf_valid;
   assign if_pc       = buf_out.pc;
   assign if_pc_plus2 = buf_out.pc_plus2;
   assign if_instr    = buf_out.instr;

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_wait_cycles <= '0;
         perf_discards    <= '0;
      end else begin
         if (imem_read && !imem_resp && perf_wait_cycles != '1) begin
            perf_wait_cycles <= perf_wait_cycles + 32'd1;
         end
         if (drop && perf_discards != '1) begin
            perf_discards <= perf_discards + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized scoreboard bench for fetch_stage
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_read;
   logic [15:0] imem_address;
   logic [15:0] imem_rdata = '0;
   logic        imem_resp = 1'b0;
   logic        branch_taken = 1'b0;
   logic [15:0] branch_target = '0;
   logic        id_ready = 1'b0;
   logic        if_valid;
   logic [15:0] if_pc;
   logic [15:0] if_pc_plus2;
   logic [15:0] if_instr;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_wait_cycles;
   logic [15:0] perf_discards;
`endif

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk           (clk),
      .reset         (reset),
      .imem_read     (imem_read),
      .imem_address  (imem_address),
      .imem_rdata    (imem_rdata),
      .imem_resp     (imem_resp),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .id_ready      (id_ready),
      .if_valid      (if_valid),
      .if_pc         (if_pc),
      .if_pc_plus2   (if_pc_plus2),
      .if_instr      (if_instr)
`ifdef FETCH_PERF_EN
      ,
      .perf_wait_cycles (perf_wait_cycles),
      .perf_discards    (perf_discards)
`endif
   );

   typedef struct {
      logic [15:0] pc;
      logic [15:0] instr;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          n_cmp = 0;
   int          n_fail = 0;
   int          cycle_no = 0;
   logic        phase_a = 1'b1;
   logic        prev_reset = 1'b1;

   // reference model: program-order PC stream plus an abstract cache
   logic        busy = 1'b0;
   logic [15:0] req_addr = '0;
   int          cnt = 0;
   logic [15:0] next_fetch = 16'h0000;
   logic        doomed = 1'b0;
   logic [31:0] m_wait = '0;
   logic [15:0] m_disc = '0;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h5A3C;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle_no);
      end
   endtask

   initial begin
      for (int cyc = 0; cyc < 3400; cyc++) begin
         @(posedge clk);
         #1;
         cycle_no = cyc;
         phase_a  = (cyc < 200);
         reset    = (cyc < 3) || (!phase_a && $urandom_range(0, 199) == 0);
         id_ready = phase_a ? 1'b1 : ($urandom_range(0, 9) < 7);
         branch_taken = !reset && !phase_a && ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 3) == 0) begin
            branch_target = 16'hFFFA + 16'(2 * $urandom_range(0, 2));
         end else begin
            branch_target = 16'($urandom) & 16'hFFFE;
         end
         #1;
         imem_resp  = 1'b0;
         imem_rdata = 16'($urandom);
         if (reset) begin
            busy = 1'b0;
         end else begin
            if (imem_read && !busy) begin
               check("req_addr", 32'(imem_address), 32'(next_fetch));
               busy     = 1'b1;
               req_addr = imem_address;
               cnt      = phase_a ? 0 : $urandom_range(0, 3);
            end else if (busy) begin
               check("addr_stable", 32'(imem_address), 32'(req_addr));
               check("read_held", 32'(imem_read), 32'd1);
            end
            if (busy && cnt == 0) begin
               imem_resp  = 1'b1;
               imem_rdata = mem_word(req_addr);
            end else if (busy) begin
               cnt--;
            end
         end
         @(negedge clk);
         #1;
         if (reset) begin
            sb.delete();
            next_fetch = 16'h0000;
            doomed     = 1'b0;
            m_wait     = '0;
            m_disc     = '0;
         end else begin
            if (imem_read && !imem_resp && m_wait != '1) m_wait++;
            if (imem_resp) begin
               busy = 1'b0;
               if (branch_taken || doomed) begin
                  doomed = 1'b0;
                  if (m_disc != '1) m_disc++;
               end else begin
                  sb.push_back('{pc: next_fetch, instr: mem_word(next_fetch)});
                  next_fetch = next_fetch + 16'd2;
               end
            end
            if (branch_taken) begin
               sb.delete();
               next_fetch = branch_target;
               doomed     = busy;
            end
         end
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

   always @(negedge clk) begin
      if (prev_reset) begin
         check("rst_valid", 32'(if_valid), 32'd0);
         check("rst_pc", 32'(if_pc), 32'd0);
         check("rst_pc_plus2", 32'(if_pc_plus2), 32'd0);
         check("rst_instr", 32'(if_instr), 32'd0);
      end
      check("imem_read_rule", 32'(imem_read), 32'(!reset && (!if_valid || id_ready)));
      if (if_valid) begin
         check("pc_plus2_rel", 32'(if_pc_plus2), 32'(16'(if_pc + 16'd2)));
      end
      if (phase_a && cycle_no >= 5) begin
         check("throughput", 32'(if_valid), 32'd1);
      end
`ifdef FETCH_PERF_EN
      check("perf_wait", perf_wait_cycles, m_wait);
      check("perf_disc", 32'(perf_discards), 32'(m_disc));
`endif
      if (if_valid && id_ready && !branch_taken && !reset) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL sb_empty: got transfer pc %0h expected none (cycle %0d)", if_pc, cycle_no);
         end else begin
            mon_e = sb.pop_front();
            check("if_pc", 32'(if_pc), 32'(mon_e.pc));
            check("if_pc_plus2", 32'(if_pc_plus2), 32'(16'(mon_e.pc + 16'd2)));
            check("if_instr", 32'(if_instr), 32'(mon_e.instr));
         end
      end
      prev_reset = reset;
   end

endmodule
